// File: rtl/param_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module      : param_updown_counter
//  Description : Parametrised synchronous up/down modulo counter with wrap or
//                saturate mode, clamped parallel load, sticky boundary flag
//                and a combinational terminal count for cascading.
//  Revision    : 1.0 - initial release
// ============================================================================
module param_updown_counter #(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 16,
    parameter bit SATURATE  = 1'b0,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] c_max     = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] c_zero    = '0;
    localparam logic [WIDTH-1:0] c_rst_val = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic             r_ovf;

    logic             w_at_top;
    logic             w_at_bot;
    logic             w_at_bound;
    logic             w_event;
    logic [WIDTH-1:0] w_load_q;
    logic [WIDTH-1:0] w_step_q;

    assign w_at_top   = (r_q == c_max);
    assign w_at_bot   = (r_q == c_zero);
    assign w_at_bound = up ? w_at_top : w_at_bot;

    // tc ignores load so a cascade stage sees only its own count position
    assign tc      = en & w_at_bound;
    assign w_event = tc & ~load;

    generate
        if (MODULUS == 2**WIDTH) begin : g_no_clamp
            assign w_load_q = load_val;
        end else begin : g_clamp
            assign w_load_q = (load_val > c_max) ? c_max : load_val;
        end
    endgenerate

    always_comb begin
        w_step_q = r_q;
        if (w_event) begin
            // saturate mode keeps r_q, which already sits on the boundary
            if (!SATURATE) begin
                w_step_q = up ? c_zero : c_max;
            end
        end else if (up) begin
            w_step_q = r_q + WIDTH'(1);
        end else begin
            w_step_q = r_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q    <= c_rst_val;
            r_wrap <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_wrap <= w_event;
            if (w_event) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end
            if (load) begin
                r_q <= w_load_q;
            end else if (en) begin
                r_q <= w_step_q;
            end
        end
    end

    assign q    = r_q;
    assign wrap = r_wrap;
    assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_param_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_param_updown_counter
//  Description : Scoreboard bench for param_updown_counter: wrap and saturate
//                instances plus a two-digit decade cascade.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_param_updown_counter;

    localparam int W  = 4;
    localparam int M  = 10;
    localparam int RV = 3;

    typedef struct { int q; bit wrap; bit ovf; } st_t;
    typedef struct { int q; bit wrap; bit ovf; bit tc; } exp_t;
    typedef struct { int n; bit lw; bit lo; bit mw; bit mo; bit ltc; bit mtc; } cexp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, en, up, load, clr_ovf;
    logic [W-1:0] load_val;
    logic [W-1:0] q_w, q_s;
    logic         tc_w, wrap_w, ovf_w, tc_s, wrap_s, ovf_s;

    logic         c_rst, c_en;
    logic [W-1:0] lsb_q, msb_q;
    logic         lsb_tc, msb_tc, lsb_wrap, msb_wrap, lsb_ovf, msb_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t  qw[$];
    exp_t  qs[$];
    cexp_t qc[$];

    st_t mw, ms;
    int  cn;
    bit  clw, clo, cmw, cmo;

    param_updown_counter #(.WIDTH(W), .MODULUS(M), .SATURATE(1'b0), .RESET_VAL(0)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .clr_ovf(clr_ovf), .q(q_w), .tc(tc_w), .wrap(wrap_w), .ovf(ovf_w));

    param_updown_counter #(.WIDTH(W), .MODULUS(M), .SATURATE(1'b1), .RESET_VAL(RV)) u_sat (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .clr_ovf(clr_ovf), .q(q_s), .tc(tc_s), .wrap(wrap_s), .ovf(ovf_s));

    param_updown_counter #(.WIDTH(W), .MODULUS(M), .SATURATE(1'b0), .RESET_VAL(0)) u_lsb (
        .clk(clk), .rst(c_rst), .en(c_en), .up(1'b1), .load(1'b0), .load_val(4'd0),
        .clr_ovf(1'b0), .q(lsb_q), .tc(lsb_tc), .wrap(lsb_wrap), .ovf(lsb_ovf));

    param_updown_counter #(.WIDTH(W), .MODULUS(M), .SATURATE(1'b0), .RESET_VAL(0)) u_msb (
        .clk(clk), .rst(c_rst), .en(lsb_tc), .up(1'b1), .load(1'b0), .load_val(4'd0),
        .clr_ovf(1'b0), .q(msb_q), .tc(msb_tc), .wrap(msb_wrap), .ovf(msb_ovf));

    task automatic chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference: one edge of a modulo-M counter, from the behavioural rules
    function automatic st_t nxt(st_t s, bit sat, int rv, bit r, bit e, bit u,
                                bit ld, int lv, bit clr);
        st_t n;
        bit  ev;
        n = s;
        if (r) begin
            n.q = rv; n.wrap = 0; n.ovf = 0;
            return n;
        end
        ev = e && !ld && (u ? (s.q + 1 == M) : (s.q == 0));
        if (ld) begin
            n.q = (lv >= M) ? M - 1 : lv;
        end else if (e) begin
            if (u) n.q = sat ? ((s.q + 1 > M - 1) ? M - 1 : s.q + 1) : (s.q + 1) % M;
            else   n.q = sat ? ((s.q - 1 < 0) ? 0 : s.q - 1) : (s.q - 1 + M) % M;
        end
        n.wrap = ev;
        n.ovf  = ev ? 1'b1 : (clr ? 1'b0 : s.ovf);
        return n;
    endfunction

    task automatic step(bit r, bit e, bit u, bit ld, int lv, bit clr);
        rst = r; en = e; up = u; load = ld; load_val = W'(lv); clr_ovf = clr;
        qw.push_back('{mw.q, mw.wrap, mw.ovf, e && (u ? mw.q == M - 1 : mw.q == 0)});
        qs.push_back('{ms.q, ms.wrap, ms.ovf, e && (u ? ms.q == M - 1 : ms.q == 0)});
        mw = nxt(mw, 1'b0, 0,  r, e, u, ld, lv, clr);
        ms = nxt(ms, 1'b1, RV, r, e, u, ld, lv, clr);
        @(posedge clk); #1;
    endtask

    // Two-digit decade counter model: value 0..99, lsb = n%10, msb = n/10
    task automatic cstep(bit r, bit e);
        bit lev, mev;
        c_rst = r; c_en = e;
        qc.push_back('{cn, clw, clo, cmw, cmo, e && (cn % 10 == 9), e && (cn == 99)});
        if (r) begin
            cn = 0; clw = 0; clo = 0; cmw = 0; cmo = 0;
        end else begin
            lev = e && (cn % 10 == 9);
            mev = e && (cn == 99);
            if (e) cn = (cn + 1) % 100;
            clw = lev; clo = clo | lev;
            cmw = mev; cmo = cmo | mev;
        end
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        exp_t  ew, es;
        cexp_t ec;
        if (qw.size() > 0) begin
            ew = qw.pop_front();
            chk("wrap_q",    int'(q_w),    ew.q);
            chk("wrap_wrap", int'(wrap_w), int'(ew.wrap));
            chk("wrap_ovf",  int'(ovf_w),  int'(ew.ovf));
            chk("wrap_tc",   int'(tc_w),   int'(ew.tc));
        end
        if (qs.size() > 0) begin
            es = qs.pop_front();
            chk("sat_q",    int'(q_s),    es.q);
            chk("sat_wrap", int'(wrap_s), int'(es.wrap));
            chk("sat_ovf",  int'(ovf_s),  int'(es.ovf));
            chk("sat_tc",   int'(tc_s),   int'(es.tc));
        end
        if (qc.size() > 0) begin
            ec = qc.pop_front();
            chk("casc_lsb_q",  int'(lsb_q),    ec.n % 10);
            chk("casc_msb_q",  int'(msb_q),    ec.n / 10);
            chk("casc_lsb_tc", int'(lsb_tc),   int'(ec.ltc));
            chk("casc_msb_tc", int'(msb_tc),   int'(ec.mtc));
            chk("casc_lsb_wr", int'(lsb_wrap), int'(ec.lw));
            chk("casc_msb_wr", int'(msb_wrap), int'(ec.mw));
            chk("casc_lsb_ov", int'(lsb_ovf),  int'(ec.lo));
            chk("casc_msb_ov", int'(msb_ovf),  int'(ec.mo));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete (got timeout, expected finish)");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0; clr_ovf = 1'b0;
        c_rst = 1'b1; c_en = 1'b0;
        @(posedge clk); #1;
        mw = '{0, 1'b0, 1'b0};
        ms = '{RV, 1'b0, 1'b0};
        cn = 0; clw = 0; clo = 0; cmw = 0; cmo = 0;

        // reset, then count up through the wrap
        step(1, 0, 1, 0, 0, 0);
        repeat (12) step(0, 1, 1, 0, 0, 0);
        // count down from 0, then clear ovf with no event
        step(0, 0, 0, 1, 0, 0);
        repeat (12) step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        // clamped load, load beats count, clr_ovf loses to an event
        step(0, 0, 1, 1, 13, 0);
        step(0, 1, 1, 1, 13, 0);
        step(0, 1, 1, 0, 0, 1);
        repeat (3) step(0, 1, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        repeat (3) step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 15, 0);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(49, 0) == 0,
                 $urandom_range(3, 0) != 0,
                 1'($urandom_range(1, 0)),
                 $urandom_range(9, 0) == 0,
                 int'($urandom_range(15, 0)),
                 $urandom_range(9, 0) == 0);
        end

        // cascade: full 100-count cycle, then reset mid-count at 57
        repeat (2) cstep(1, 0);
        repeat (100) cstep(0, 1);
        repeat (57) cstep(0, 1);
        cstep(1, 1);
        repeat (3) cstep(0, 1);
        repeat (2) cstep(0, $urandom_range(1, 0) == 1);

        @(negedge clk); #1;
        chk("drain_wrap", qw.size(), 0);
        chk("drain_sat",  qs.size(), 0);
        chk("drain_casc", qc.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
